// File: rtl/nios_led_ctrl_if.sv
// Avalon-MM s1 slave bus for the LED controller: word address, select, write strobe, data.
// Purely combinational wiring; the slave answers reads in the same cycle.
// No wait states, so there is no waitrequest or other backpressure signal.
interface nios_led_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/nios_led_ctrl.sv
// LED output PIO with atomic set/clear/toggle, per-channel blink and global PWM brightness.
// Register writes commit at the write edge; out_port follows register state one cycle later.
// Never stalls the bus: writes are accepted every cycle and reads are combinational.
module nios_led_ctrl #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      PRESC_W    = 24,
  parameter int unsigned      PWM_W      = 8,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  nios_led_ctrl_if.slave   s1,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_TOGGLE = 3'd3;
  localparam logic [2:0] A_MODE   = 3'd4;
  localparam logic [2:0] A_PRESC  = 3'd5;
  localparam logic [2:0] A_BRIGHT = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_mode;
  logic [PRESC_W-1:0] r_presc;
  logic [PWM_W-1:0]   r_bright;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic               r_phase;
  logic [PWM_W-1:0]   r_pwm_cnt;

  logic               w_wr;
  logic [WIDTH-1:0]   w_wd;
  logic               w_presc_wr;
  logic               w_pwm_on;
  logic [WIDTH-1:0]   w_led;
  logic               w_unused;

  assign w_wr       = s1.chipselect & ~s1.write_n;
  assign w_wd       = s1.writedata[WIDTH-1:0];
  assign w_presc_wr = w_wr && (s1.address == A_PRESC);
  // Upper writedata bits are deliberately ignored for narrow fields.
  assign w_unused   = &{1'b0, s1.writedata};

  // Software-visible registers; the atomic ops read-modify-write DATA in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= RESET_DATA;
      r_mode   <= '0;
      r_presc  <= '0;
      r_bright <= '1;
    end else if (w_wr) begin
      case (s1.address)
        A_DATA:   r_data   <= w_wd;
        A_SET:    r_data   <= r_data | w_wd;
        A_CLR:    r_data   <= r_data & ~w_wd;
        A_TOGGLE: r_data   <= r_data ^ w_wd;
        A_MODE:   r_mode   <= w_wd;
        A_PRESC:  r_presc  <= s1.writedata[PRESC_W-1:0];
        A_BRIGHT: r_bright <= s1.writedata[PWM_W-1:0];
        default:  ;
      endcase
    end
  end

  // Blink prescaler: phase flips after PRESCALE+1 cycles; a PRESCALE write restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_presc_wr) begin
      r_presc_cnt <= '0;
    end else if (r_presc_cnt == r_presc) begin
      r_presc_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  // Free-running PWM counter, wraps naturally at 2^PWM_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // All-ones brightness forces fully on so the duty can reach 100%.
  assign w_pwm_on = (r_pwm_cnt < r_bright) || (r_bright == '1);
  assign w_led    = r_data & (~r_mode | {WIDTH{r_phase}}) & {WIDTH{w_pwm_on}};

  // Registered pin drive built from pre-edge register and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_port <= '0;
    else       out_port <= w_led;
  end

  // Read mux, zero-extended; write-only registers read back as zero.
  always_comb begin
    s1.readdata = '0;
    case (s1.address)
      A_DATA:   s1.readdata = 32'(r_data);
      A_MODE:   s1.readdata = 32'(r_mode);
      A_PRESC:  s1.readdata = 32'(r_presc);
      A_BRIGHT: s1.readdata = 32'(r_bright);
      A_STATUS: s1.readdata = 32'(out_port);
      default:  s1.readdata = '0;
    endcase
  end

endmodule
